// File: rtl/pool_window_gather_pkg.sv
// pool_window_gather_pkg: shared pooling defaults and the window ordering contract
package pool_window_gather_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int IMG_W_DEF = 8;
  localparam int IMG_H_DEF = 8;
  typedef enum logic [2:0] {TL = 3'd1, TR = 3'd2, BL = 3'd3, BR = 3'd4} win_idx_e;
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pool_window_gather_if.sv
// pool_window_gather_if: pixel stream in, 2x2 window out
interface pool_window_gather_if import pool_window_gather_pkg::*; #(parameter int DATA_W = DATA_W_DEF) ();
  logic In_Valid;
  logic [DATA_W-1:0] In_Data;
  logic Window_Valid;
  logic [DATA_W-1:0] Window_Value_1;
  logic [DATA_W-1:0] Window_Value_2;
  logic [DATA_W-1:0] Window_Value_3;
  logic [DATA_W-1:0] Window_Value_4;
  logic Frame_Done;
  modport master (
    output In_Valid, In_Data,
    input Window_Valid, Window_Value_1, Window_Value_2, Window_Value_3, Window_Value_4, Frame_Done
  );
  modport slave (
    input In_Valid, In_Data,
    output Window_Valid, Window_Value_1, Window_Value_2, Window_Value_3, Window_Value_4, Frame_Done
  );
endinterface

// File: rtl/pool_window_gather_line_buffer.sv
// pool_line_buffer: one image row of pixels, single write port, two combinational reads
module pool_line_buffer import pool_window_gather_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int AW = cnt_w(IMG_W)
) (
  input  logic Clock,
  input  logic wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);
  logic [DATA_W-1:0] mem [IMG_W];
  always_ff @(posedge Clock)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];
endmodule

// File: rtl/pool_window_gather.sv
// pool_window_gather: builds non-overlapping stride-2 2x2 windows from a raster pixel stream
module pool_window_gather import pool_window_gather_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input logic Clock,
  input logic Reset,
  pool_window_gather_if.slave w
);
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [DATA_W-1:0] held;
  logic [DATA_W-1:0] top_left, top_right;
  logic [DATA_W-1:0] win_q [1:4];
  logic win_valid, frame_done;
  logic last_col, last_row, odd_row, odd_col, emit;
  assign last_col = col_cnt == CW'(IMG_W - 1);
  assign last_row = row_cnt == RW'(IMG_H - 1);
  assign odd_row = row_cnt[0];
  assign odd_col = col_cnt[0];
  assign emit = w.In_Valid && odd_row && odd_col;
  // Only even rows land in the buffer; odd rows consume it as the window's top half.
  pool_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .AW(CW)) u_line_buf (
    .Clock(Clock),
    .wr_en(w.In_Valid && !odd_row),
    .wr_addr(col_cnt),
    .wr_data(w.In_Data),
    .rd_addr_a(col_cnt - CW'(1)),
    .rd_addr_b(col_cnt),
    .rd_data_a(top_left),
    .rd_data_b(top_right)
  );
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
      held <= '0;
      win_valid <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 1; i <= 4; i++) win_q[i] <= '0;
    end else begin
      win_valid <= emit;
      frame_done <= emit && last_col && last_row;
      if (w.In_Valid) begin
        col_cnt <= last_col ? '0 : col_cnt + CW'(1);
        if (last_col) row_cnt <= last_row ? '0 : row_cnt + RW'(1);
        if (odd_row && !odd_col) held <= w.In_Data;
      end
      if (emit) begin
        win_q[int'(TL)] <= top_left;
        win_q[int'(TR)] <= top_right;
        win_q[int'(BL)] <= held;
        win_q[int'(BR)] <= w.In_Data;
      end
    end
  end
  assign w.Window_Valid = win_valid;
  assign w.Frame_Done = frame_done;
  assign w.Window_Value_1 = win_q[int'(TL)];
  assign w.Window_Value_2 = win_q[int'(TR)];
  assign w.Window_Value_3 = win_q[int'(BL)];
  assign w.Window_Value_4 = win_q[int'(BR)];
endmodule
